// File: rtl/uart_mmio_periph_pkg.sv
// Shared types and constants for the UART MMIO peripheral.
package uart_mmio_periph_pkg;

  typedef enum logic [1:0] {
    T_IDLE  = 2'd0,
    T_START = 2'd1,
    T_DATA  = 2'd2,
    T_STOP  = 2'd3
  } tx_state_e;

  typedef enum logic [1:0] {
    R_IDLE  = 2'd0,
    R_START = 2'd1,
    R_DATA  = 2'd2,
    R_STOP  = 2'd3
  } rx_state_e;

  // Core-side MMIO addresses decoded outside this block.
  localparam logic [31:0] UART_DATA_ADDR = 32'h1000_0000;
  localparam logic [31:0] UART_STAT_ADDR = 32'h1000_0004;

  // Width of a counter that must reach n-1 (at least one bit).
  function automatic int cnt_width(input int n);
    if (n <= 2) return 1;
    return $clog2(n);
  endfunction

endpackage

// File: rtl/uart_mmio_periph_rx_fifo.sv
// Small receive FIFO. Pointers carry one extra wrap bit so full and empty
// are told apart by the MSBs. A pop on a full FIFO frees the slot the
// same-cycle push needs, so both succeed.
module uart_rx_fifo #(
  parameter int RX_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  logic [7:0] push_data,
  input  logic       pop,
  output logic [7:0] head,
  output logic       empty,
  output logic       full
);

  localparam int AW = $clog2(RX_DEPTH);

  logic [AW:0] wr_q, wr_d;
  logic [AW:0] rd_q, rd_d;
  logic [7:0]  mem_q [RX_DEPTH];
  logic [7:0]  mem_d [RX_DEPTH];
  logic        pop_ok;
  logic        push_ok;

  assign empty   = (wr_q == rd_q);
  assign full    = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);
  assign head    = empty ? 8'h00 : mem_q[rd_q[AW-1:0]];

  // Next pointer and storage values.
  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    mem_d = mem_q;
    if (push_ok) begin
      mem_d[wr_q[AW-1:0]] = push_data;
      wr_d = wr_q + 1'b1;
    end
    if (pop_ok) begin
      rd_d = rd_q + 1'b1;
    end
  end

  // Pointer and storage registers; reset empties the FIFO.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_q <= '0;
      rd_q <= '0;
      for (int i = 0; i < RX_DEPTH; i++) mem_q[i] <= 8'h00;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      mem_q <= mem_d;
    end
  end

endmodule

// File: rtl/uart_mmio_periph.sv
// UART peripheral behind the core's MMIO port: 8N1 transmitter fed by
// byte-write strobes and a receiver that queues bytes into a small FIFO.
// Handshake: tx_we is a one-cycle strobe accepted only while tx_busy=0;
// rx_re is a one-cycle strobe that pops only while rx_valid=1.
module uart_mmio_periph
  import uart_mmio_periph_pkg::*;
#(
  parameter int CLK_HZ   = 100_000_000,
  parameter int BAUD     = 115200,
  parameter int RX_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_we,
  output logic       tx_busy,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_re,
  output logic       rx_overrun,
  output logic       uart_txd,
  input  logic       uart_rxd
);

  localparam int CLKS_PER_BIT = CLK_HZ / BAUD;
  localparam int CNT_W        = cnt_width(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  // ---------------- transmitter ----------------
  tx_state_e        tx_state_q, tx_state_d;
  logic [CNT_W-1:0] tx_cnt_q, tx_cnt_d;
  logic [7:0]       tx_shift_q, tx_shift_d;
  logic [2:0]       tx_idx_q, tx_idx_d;
  logic             txd_q, txd_d;

  assign tx_busy  = (tx_state_q != T_IDLE);
  assign uart_txd = txd_q;

  // TX next state; the line value is derived from the next state so it
  // changes on the same edge as the state register.
  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_shift_d = tx_shift_q;
    tx_idx_d   = tx_idx_q;
    case (tx_state_q)
      T_IDLE: begin
        if (tx_we) begin
          tx_shift_d = tx_data;
          tx_cnt_d   = '0;
          tx_idx_d   = '0;
          tx_state_d = T_START;
        end
      end
      T_START: begin
        if (tx_cnt_q == BIT_LAST) begin
          tx_cnt_d   = '0;
          tx_state_d = T_DATA;
        end else begin
          tx_cnt_d = tx_cnt_q + CNT_ONE;
        end
      end
      T_DATA: begin
        if (tx_cnt_q == BIT_LAST) begin
          tx_cnt_d   = '0;
          tx_shift_d = {1'b0, tx_shift_q[7:1]};
          tx_idx_d   = tx_idx_q + 3'd1;
          if (tx_idx_q == 3'd7) tx_state_d = T_STOP;
        end else begin
          tx_cnt_d = tx_cnt_q + CNT_ONE;
        end
      end
      T_STOP: begin
        if (tx_cnt_q == BIT_LAST) begin
          tx_cnt_d   = '0;
          tx_state_d = T_IDLE;
        end else begin
          tx_cnt_d = tx_cnt_q + CNT_ONE;
        end
      end
      default: tx_state_d = T_IDLE;
    endcase
    case (tx_state_d)
      T_START: txd_d = 1'b0;
      T_DATA:  txd_d = tx_shift_d[0];
      default: txd_d = 1'b1;
    endcase
  end

  // TX registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      tx_state_q <= T_IDLE;
      tx_cnt_q   <= '0;
      tx_shift_q <= 8'h00;
      tx_idx_q   <= 3'd0;
      txd_q      <= 1'b1;
    end else begin
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_shift_q <= tx_shift_d;
      tx_idx_q   <= tx_idx_d;
      txd_q      <= txd_d;
    end
  end

  // ---------------- receiver ----------------
  logic rx_meta_q, rx_sync_q;

  // Two-flop synchronizer for the asynchronous RX pin; idles high.
  always_ff @(posedge clk) begin
    if (!rst) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
    end else begin
      rx_meta_q <= uart_rxd;
      rx_sync_q <= rx_meta_q;
    end
  end

  rx_state_e        rx_state_q, rx_state_d;
  logic [CNT_W-1:0] rx_cnt_q, rx_cnt_d;
  logic [7:0]       rx_shift_q, rx_shift_d;
  logic [2:0]       rx_idx_q, rx_idx_d;
  logic             rx_push;
  logic             rx_overrun_q, rx_overrun_d;
  logic             fifo_empty, fifo_full, pop_ok;

  // RX next state: half-bit start check, then mid-bit samples.
  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q;
    rx_shift_d = rx_shift_q;
    rx_idx_d   = rx_idx_q;
    rx_push    = 1'b0;
    case (rx_state_q)
      R_IDLE: begin
        if (!rx_sync_q) begin
          rx_cnt_d   = '0;
          rx_state_d = R_START;
        end
      end
      R_START: begin
        if (rx_cnt_q == HALF_LAST) begin
          rx_cnt_d   = '0;
          rx_idx_d   = '0;
          rx_state_d = rx_sync_q ? R_IDLE : R_DATA;
        end else begin
          rx_cnt_d = rx_cnt_q + CNT_ONE;
        end
      end
      R_DATA: begin
        if (rx_cnt_q == BIT_LAST) begin
          rx_cnt_d   = '0;
          rx_shift_d = {rx_sync_q, rx_shift_q[7:1]};
          rx_idx_d   = rx_idx_q + 3'd1;
          if (rx_idx_q == 3'd7) rx_state_d = R_STOP;
        end else begin
          rx_cnt_d = rx_cnt_q + CNT_ONE;
        end
      end
      R_STOP: begin
        if (rx_cnt_q == BIT_LAST) begin
          rx_cnt_d   = '0;
          rx_push    = rx_sync_q;
          rx_state_d = R_IDLE;
        end else begin
          rx_cnt_d = rx_cnt_q + CNT_ONE;
        end
      end
      default: rx_state_d = R_IDLE;
    endcase
  end

  assign pop_ok = rx_re && !fifo_empty;

  // Sticky overrun: set when a push finds the FIFO full with no pop to
  // make room, cleared by any effective pop.
  always_comb begin
    rx_overrun_d = rx_overrun_q;
    if (pop_ok) rx_overrun_d = 1'b0;
    if (rx_push && fifo_full && !pop_ok) rx_overrun_d = 1'b1;
  end

  // RX registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      rx_state_q   <= R_IDLE;
      rx_cnt_q     <= '0;
      rx_shift_q   <= 8'h00;
      rx_idx_q     <= 3'd0;
      rx_overrun_q <= 1'b0;
    end else begin
      rx_state_q   <= rx_state_d;
      rx_cnt_q     <= rx_cnt_d;
      rx_shift_q   <= rx_shift_d;
      rx_idx_q     <= rx_idx_d;
      rx_overrun_q <= rx_overrun_d;
    end
  end

  uart_rx_fifo #(
    .RX_DEPTH(RX_DEPTH)
  ) u_rx_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (rx_push),
    .push_data(rx_shift_q),
    .pop      (rx_re),
    .head     (rx_data),
    .empty    (fifo_empty),
    .full     (fifo_full)
  );

  assign rx_valid   = !fifo_empty;
  assign rx_overrun = rx_overrun_q;

endmodule

// File: tb/tb_uart_mmio_periph.sv
// Directed bench for uart_mmio_periph at 10 clocks per bit.
module tb_uart_mmio_periph;

  localparam int CLK_HZ   = 1000;
  localparam int BAUD     = 100;
  localparam int CPB      = 10;
  localparam int RX_DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_we = 1'b0;
  logic       tx_busy;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_re = 1'b0;
  logic       rx_overrun;
  logic       uart_txd;
  logic       uart_rxd = 1'b1;

  int n_tests = 0;
  int n_fail  = 0;
  logic [7:0] exp_q[$];

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  uart_mmio_periph #(
    .CLK_HZ  (CLK_HZ),
    .BAUD    (BAUD),
    .RX_DEPTH(RX_DEPTH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .tx_data   (tx_data),
    .tx_we     (tx_we),
    .tx_busy   (tx_busy),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_re     (rx_re),
    .rx_overrun(rx_overrun),
    .uart_txd  (uart_txd),
    .uart_rxd  (uart_rxd)
  );

  // ---------------- checker ----------------
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Strobe byte b and check every cycle of the frame; optionally strobe
  // 0xFF at frame offset glitch_at, which must be ignored.
  task automatic tx_check(input logic [7:0] b, input int glitch_at);
    logic [9:0] frame;
    frame   = {1'b1, b, 1'b0};
    tx_data = b;
    tx_we   = 1'b1;
    @(negedge clk);
    tx_we   = 1'b0;
    tx_data = 8'h00;
    for (int i = 0; i < 10 * CPB; i++) begin
      chk("tx_txd", uart_txd, frame[i/CPB]);
      chk("tx_busy", tx_busy, 1);
      tx_we   = (i == glitch_at);
      tx_data = (i == glitch_at) ? 8'hFF : 8'h00;
      @(negedge clk);
    end
    tx_we   = 1'b0;
    tx_data = 8'h00;
    chk("tx_busy_end", tx_busy, 0);
    chk("tx_txd_end", uart_txd, 1);
  endtask

  task automatic rx_frame(input logic [7:0] b, input logic stop);
    logic [9:0] f;
    f = {stop, b, 1'b0};
    for (int k = 0; k < 10; k++) begin
      uart_rxd = f[k];
      repeat (CPB) @(negedge clk);
    end
    uart_rxd = 1'b1;
  endtask

  task automatic wait_valid(input string tag);
    int n;
    n = 0;
    while (!rx_valid && n < 30) begin
      @(negedge clk);
      n++;
    end
    chk(tag, rx_valid, 1);
  endtask

  // Compare head against the scoreboard, then pop it.
  task automatic rx_pop(input string tag);
    logic [7:0] e;
    e = (exp_q.size() == 0) ? 8'h00 : exp_q.pop_front();
    chk(tag, rx_data, e);
    rx_re = 1'b1;
    @(negedge clk);
    rx_re = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [9:0] rf;

    idle(3);
    chk("rst_txd", uart_txd, 1);
    chk("rst_busy", tx_busy, 0);
    chk("rst_valid", rx_valid, 0);
    chk("rst_data", rx_data, 0);
    chk("rst_ovr", rx_overrun, 0);
    rst = 1'b1;
    idle(2);

    // TX 0xA5, then the same frame with an ignored mid-frame strobe.
    tx_check(8'hA5, -1);
    idle(5);
    tx_check(8'hA5, 14);
    for (int i = 0; i < 3 * CPB; i++) begin
      chk("tx_no_second", {tx_busy, uart_txd}, 2'b01);
      @(negedge clk);
    end

    // Back-to-back: second strobe lands in the first idle cycle.
    tx_check(8'h0F, -1);
    tx_check(8'hC3, -1);
    idle(5);

    // RX 0x3C and pop.
    rx_frame(8'h3C, 1'b1);
    exp_q.push_back(8'h3C);
    wait_valid("rx_3c_valid");
    rx_pop("rx_3c_data");
    chk("rx_3c_valid_after", rx_valid, 0);
    chk("rx_3c_data_after", rx_data, 0);
    idle(5);

    // Overflow: five frames into a four-entry FIFO.
    for (int v = 1; v <= 5; v++) begin
      rx_frame(8'(v), 1'b1);
      if (v <= RX_DEPTH) exp_q.push_back(8'(v));
      idle(3);
    end
    idle(10);
    chk("ovf_flag", rx_overrun, 1);
    chk("ovf_valid", rx_valid, 1);
    rx_pop("ovf_rd1");
    chk("ovf_cleared", rx_overrun, 0);
    rx_pop("ovf_rd2");
    rx_pop("ovf_rd3");
    rx_pop("ovf_rd4");
    chk("ovf_empty", rx_valid, 0);
    chk("ovf_empty_data", rx_data, 0);
    rx_re = 1'b1;
    @(negedge clk);
    rx_re = 1'b0;
    chk("pop_empty_valid", rx_valid, 0);
    chk("pop_empty_ovr", rx_overrun, 0);

    // Noise: short low pulse, then a frame with a bad stop bit.
    uart_rxd = 1'b0;
    idle(3);
    uart_rxd = 1'b1;
    idle(20);
    chk("glitch_valid", rx_valid, 0);
    rx_frame(8'h77, 1'b0);
    idle(30);
    chk("frame_err_valid", rx_valid, 0);
    chk("frame_err_ovr", rx_overrun, 0);
    chk("frame_err_data", rx_data, 0);

    // Reset mid-frame with one byte queued and both directions active.
    rx_frame(8'h11, 1'b1);
    wait_valid("pre_rst_valid");
    chk("pre_rst_data", rx_data, 8'h11);
    idle(5);
    rf = {1'b1, 8'h66, 1'b0};
    for (int i = 0; i < 4 * CPB + 5; i++) begin
      uart_rxd = rf[i/CPB];
      tx_we    = (i == 0);
      tx_data  = (i == 0) ? 8'h33 : 8'h00;
      @(negedge clk);
    end
    tx_we = 1'b0;
    chk("pre_rst_busy", tx_busy, 1);
    rst = 1'b0;
    @(negedge clk);
    chk("mid_rst_txd", uart_txd, 1);
    chk("mid_rst_busy", tx_busy, 0);
    chk("mid_rst_valid", rx_valid, 0);
    chk("mid_rst_data", rx_data, 0);
    chk("mid_rst_ovr", rx_overrun, 0);
    rst      = 1'b1;
    uart_rxd = 1'b1;
    idle(20);
    chk("post_rst_idle", {tx_busy, uart_txd, rx_valid}, 3'b010);
    rx_frame(8'h5A, 1'b1);
    exp_q.push_back(8'h5A);
    wait_valid("post_rst_valid");
    rx_pop("post_rst_5a");
    chk("post_rst_empty", rx_valid, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
